// File: rtl/usb_xact_ctrl.sv
// usb_xact_ctrl: host-side USB transaction sequencer.
// Runs one OUT (token, DATA0, wait handshake) or IN (token, wait DATA0, send
// ACK) transaction per start, with device-silence timeout and bounded retry.
// Ports:
//   clk, rst           clock, async active-high reset
//   start, is_in       transaction request / direction (sampled together)
//   tx_req/type/pid    transmit pipeline request, held until tx_done
//   tx_done            transmit pipeline completion pulse
//   rx_en              line direction: 1 = device may drive
//   rx_valid/pid/crc   decoded packet from the receive pipeline
//   busy, done         transaction in progress / one-cycle completion pulse
//   success, fail      result, valid with done, held until next start
module usb_xact_ctrl #(
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_in,
  output logic       tx_req,
  output logic [1:0] tx_type,
  output logic [3:0] tx_pid,
  input  logic       tx_done,
  output logic       rx_en,
  input  logic       rx_valid,
  input  logic [3:0] rx_pid,
  input  logic       rx_crc_ok,
  output logic       busy,
  output logic       done,
  output logic       success,
  output logic       fail
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  // NAK needs no decode: it takes the same retry path as any unexpected PID.

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] RTRY_LAST = 4'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    IDLE, TOK, DATA_TX, WAIT_HS, WAIT_DATA, HS_TX, FIN
  } state_t;

  state_t     state, nxt;
  logic       is_in_q;
  logic [7:0] timer;
  logic [3:0] retry;
  logic       fin_ok, retry_go, timeout, tok_in;

  assign timeout = (timer == TMO_LAST);
  // Token direction comes straight from the input on the accepting edge.
  assign tok_in  = (state == IDLE) ? is_in : is_in_q;

  always_comb begin
    nxt      = state;
    fin_ok   = 1'b0;
    retry_go = 1'b0;
    case (state)
      IDLE:    if (start) nxt = TOK;
      TOK:     if (tx_done) nxt = is_in_q ? WAIT_DATA : DATA_TX;
      DATA_TX: if (tx_done) nxt = WAIT_HS;
      WAIT_HS: begin
        // rx_valid checked first so it wins over a same-cycle timeout
        if (rx_valid) begin
          if (rx_pid == PID_ACK && rx_crc_ok) begin
            nxt    = FIN;
            fin_ok = 1'b1;
          end else if (rx_pid == PID_STALL) begin
            nxt = FIN;
          end else begin
            retry_go = 1'b1;
          end
        end else if (timeout) begin
          retry_go = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (rx_valid) begin
          if (rx_pid == PID_DATA0 && rx_crc_ok) nxt = HS_TX;
          else if (rx_pid == PID_STALL)         nxt = FIN;
          else                                  retry_go = 1'b1;
        end else if (timeout) begin
          retry_go = 1'b1;
        end
      end
      HS_TX: begin
        if (tx_done) begin
          nxt    = FIN;
          fin_ok = 1'b1;
        end
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (retry_go) nxt = (retry < RTRY_LAST) ? TOK : FIN;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      is_in_q <= 1'b0;
      timer   <= '0;
      retry   <= '0;
      tx_req  <= 1'b0;
      tx_type <= '0;
      tx_pid  <= '0;
      rx_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      success <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        is_in_q <= is_in;
        retry   <= '0;
        success <= 1'b0;
        fail    <= 1'b0;
      end
      if (retry_go && retry < RTRY_LAST) retry <= retry + 4'd1;

      if ((nxt == WAIT_HS || nxt == WAIT_DATA) && nxt != state)
        timer <= '0;
      else if (state == WAIT_HS || state == WAIT_DATA)
        timer <= timer + 8'd1;

      if (nxt == FIN) begin
        success <= fin_ok;
        fail    <= ~fin_ok;
      end

      busy   <= (nxt != IDLE) && (nxt != FIN);
      done   <= (nxt == FIN);
      rx_en  <= (nxt == WAIT_HS) || (nxt == WAIT_DATA);
      tx_req <= (nxt == TOK) || (nxt == DATA_TX) || (nxt == HS_TX);
      case (nxt)
        TOK: begin
          tx_type <= 2'd1;
          tx_pid  <= tok_in ? PID_IN : PID_OUT;
        end
        DATA_TX: begin
          tx_type <= 2'd2;
          tx_pid  <= PID_DATA0;
        end
        HS_TX: begin
          tx_type <= 2'd3;
          tx_pid  <= PID_ACK;
        end
        default: begin
          tx_type <= 2'd0;
          tx_pid  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_xact_ctrl.sv
module tb_usb_xact_ctrl;

  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_D0 = 4'b0011;
  localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_STL = 4'b1110;

  typedef struct packed {
    logic       start;
    logic       is_in;
    logic       tx_done;
    logic       rx_valid;
    logic [3:0] rx_pid;
    logic       rx_crc_ok;
  } in_t;

  typedef struct packed {
    logic       tx_req;
    logic [1:0] tx_type;
    logic [3:0] tx_pid;
    logic       rx_en;
    logic       busy;
    logic       done;
    logic       success;
    logic       fail;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, is_in = 1'b0, tx_done = 1'b0;
  logic       rx_valid = 1'b0, rx_crc_ok = 1'b0;
  logic [3:0] rx_pid = 4'd0;
  logic       tx_req, rx_en, busy, done, success, fail;
  logic [1:0] tx_type;
  logic [3:0] tx_pid;

  int errors = 0;
  int checks = 0;
  vec_t vq[$];

  usb_xact_ctrl #(.TIMEOUT(64), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .start(start), .is_in(is_in),
    .tx_req(tx_req), .tx_type(tx_type), .tx_pid(tx_pid), .tx_done(tx_done),
    .rx_en(rx_en), .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_crc_ok(rx_crc_ok),
    .busy(busy), .done(done), .success(success), .fail(fail)
  );

  always #5 clk = ~clk;

  function automatic in_t mi(input logic st, input logic in, input logic td,
                             input logic rv, input logic [3:0] pid, input logic crc);
    in_t r;
    r.start = st; r.is_in = in; r.tx_done = td;
    r.rx_valid = rv; r.rx_pid = pid; r.rx_crc_ok = crc;
    return r;
  endfunction

  function automatic out_t mo(input logic rq, input logic [1:0] ty, input logic [3:0] pid,
                              input logic rx, input logic bs, input logic dn,
                              input logic sc, input logic fl);
    out_t r;
    r.tx_req = rq; r.tx_type = ty; r.tx_pid = pid; r.rx_en = rx;
    r.busy = bs; r.done = dn; r.success = sc; r.fail = fl;
    return r;
  endfunction

  function automatic out_t cur();
    return mo(tx_req, tx_type, tx_pid, rx_en, busy, done, success, fail);
  endfunction

  task automatic add(input in_t a, input out_t b);
    vec_t v;
    v.i = a; v.o = b;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, take one clock edge, sample 1 time unit after it.
  task automatic step(input in_t a);
    start = a.start; is_in = a.is_in; tx_done = a.tx_done;
    rx_valid = a.rx_valid; rx_pid = a.rx_pid; rx_crc_ok = a.rx_crc_ok;
    @(posedge clk);
    #1;
  endtask

  in_t NOP, TXD;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    NOP = mi(0, 0, 0, 0, 4'd0, 0);
    TXD = mi(0, 0, 1, 0, 4'd0, 0);

    // OUT happy path
    add(mi(1,0,0,0,0,0),     mo(1,1,P_OUT,0,1,0,0,0));
    add(NOP,                 mo(1,1,P_OUT,0,1,0,0,0));
    add(TXD,                 mo(1,2,P_D0, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_ACK,1), mo(0,0,0,    0,0,1,1,0));
    add(NOP,                 mo(0,0,0,    0,0,0,1,0));
    // IN happy path
    add(mi(1,1,0,0,0,0),     mo(1,1,P_IN, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_D0,1),  mo(1,3,P_ACK,0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    0,0,1,1,0));
    add(NOP,                 mo(0,0,0,    0,0,0,1,0));
    // STALL in WAIT_DATA: fail, no handshake
    add(mi(1,1,0,0,0,0),     mo(1,1,P_IN, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_STL,1), mo(0,0,0,    0,0,1,0,1));
    add(NOP,                 mo(0,0,0,    0,0,0,0,1));
    // NAK then ACK on OUT
    add(mi(1,0,0,0,0,0),     mo(1,1,P_OUT,0,1,0,0,0));
    add(TXD,                 mo(1,2,P_D0, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_NAK,1), mo(1,1,P_OUT,0,1,0,0,0));
    add(TXD,                 mo(1,2,P_D0, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_ACK,1), mo(0,0,0,    0,0,1,1,0));
    add(NOP,                 mo(0,0,0,    0,0,0,1,0));
    // IN with bad CRC: retry, no ACK sent
    add(mi(1,1,0,0,0,0),     mo(1,1,P_IN, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_D0,0),  mo(1,1,P_IN, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_D0,1),  mo(1,3,P_ACK,0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    0,0,1,1,0));
    add(NOP,                 mo(0,0,0,    0,0,0,1,0));
    // Ignored inputs: rx_valid in IDLE, start while busy / in FIN, stray pulses
    add(mi(0,0,1,1,P_ACK,1), mo(0,0,0,    0,0,0,1,0));
    add(mi(1,0,0,0,0,0),     mo(1,1,P_OUT,0,1,0,0,0));
    add(mi(1,1,0,0,0,0),     mo(1,1,P_OUT,0,1,0,0,0));
    add(mi(0,0,0,1,P_ACK,1), mo(1,1,P_OUT,0,1,0,0,0));
    add(TXD,                 mo(1,2,P_D0, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_ACK,1), mo(0,0,0,    0,0,1,1,0));
    add(mi(1,1,0,0,0,0),     mo(0,0,0,    0,0,0,1,0));
    // STALL in WAIT_HS
    add(mi(1,0,0,0,0,0),     mo(1,1,P_OUT,0,1,0,0,0));
    add(TXD,                 mo(1,2,P_D0, 0,1,0,0,0));
    add(TXD,                 mo(0,0,0,    1,1,0,0,0));
    add(mi(0,0,0,1,P_STL,1), mo(0,0,0,    0,0,1,0,1));
    add(NOP,                 mo(0,0,0,    0,0,0,0,1));

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(cur()), 32'(out_t'(0)));
    rst = 1'b0;

    foreach (vq[k]) begin
      step(vq[k].i);
      chk($sformatf("vec%0d", k), 32'(cur()), 32'(vq[k].o));
    end

    // Silent device: three IN tokens, 64-cycle windows, then fail
    step(mi(1,1,0,0,0,0));
    for (int a = 0; a < 3; a++) begin
      chk($sformatf("tmo_tok%0d", a), {tx_req, tx_type, tx_pid}, {1'b1, 2'd1, P_IN});
      step(TXD);
      cnt = 0;
      while (rx_en && cnt < 200) begin
        cnt++;
        step(NOP);
      end
      chk($sformatf("tmo_window%0d", a), cnt, 64);
    end
    chk("tmo_exhaust", {done, success, fail, busy}, 4'b1010);
    step(NOP);
    chk("tmo_idle", {done, busy, fail}, 3'b001);

    // rx_valid on the timeout cycle takes priority
    step(mi(1,1,0,0,0,0));
    step(TXD);
    repeat (63) step(NOP);
    chk("edge_still_waiting", {rx_en, tx_req}, 2'b10);
    step(mi(0,0,0,1,P_D0,1));
    chk("edge_rx_wins", {tx_req, tx_type, tx_pid}, {1'b1, 2'd3, P_ACK});
    step(TXD);
    chk("edge_done", {done, success, fail}, 3'b110);
    step(NOP);

    // Reset during WAIT_HS aborts with no done
    step(mi(1,0,0,0,0,0));
    step(TXD);
    step(TXD);
    step(NOP);
    step(NOP);
    chk("rst_in_wait_hs", {rx_en, busy}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_zero", 32'(cur()), 32'(out_t'(0)));
    @(posedge clk);
    #1;
    chk("rst_no_done", {done, busy, success, fail}, 4'b0000);
    rst = 1'b0;
    step(NOP);
    chk("rst_idle_after", 32'(cur()), 32'(out_t'(0)));
    step(mi(1,0,0,0,0,0));
    chk("post_rst_tok", tx_pid, P_OUT);
    step(TXD);
    chk("post_rst_data", tx_pid, P_D0);
    step(TXD);
    step(mi(0,0,0,1,P_ACK,1));
    chk("post_rst_done", {done, success, fail, busy}, 4'b1100);
    step(NOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_xact_ctrl.md
Name: usb_xact_ctrl

Overview:
Host-side transaction sequencer for the shared DP/DM line and its encode/decode pipelines. On a start request it runs one complete OUT or IN transaction: token, then data, then handshake. It drives the transmit pipeline, switches the line between write and read, times out on device silence, and retries failed attempts up to a fixed limit. It returns a single pass or fail result to the host software interface.

Parameters:
TIMEOUT, 64, cycles to wait in a receive state before declaring the device silent (1..255)
MAX_RETRY, 3, total attempts per transaction before failure (1..15)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
start  input  1  one-cycle request to begin a transaction; ignored while busy
is_in  input  1  sampled with start: 1 = IN transaction, 0 = OUT transaction
tx_req  output  1  request to the transmit pipeline; held high until tx_done
tx_type  output  2  packet type: 0 = none, 1 = token, 2 = data, 3 = handshake
tx_pid  output  4  PID of the packet being sent
tx_done  input  1  one-cycle pulse from the transmit pipeline after EOP and J have been driven
rx_en  output  1  1 = line in read mode (device may drive), 0 = host owns the line
rx_valid  input  1  one-cycle pulse from the decode pipeline: a packet was received (EOP seen)
rx_pid  input  4  PID of the received packet; valid with rx_valid
rx_crc_ok  input  1  CRC check result; valid with rx_valid
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at the end of a transaction
success  output  1  valid with done: 1 = ACK path completed
fail  output  1  valid with done: 1 = STALL received or retries exhausted

Behaviour:
- PIDs (4-bit):
  - OUT = 0001, IN = 1001, DATA0 = 0011
  - ACK = 0010, NAK = 1010, STALL = 1110
- Reset: state IDLE; timer and retry count = 0.
  - Reset outputs: tx_req=0, tx_type=0, tx_pid=0, rx_en=0, busy=0, done=0, success=0, fail=0.
  - Reset asserted mid-transaction aborts immediately to IDLE; no done pulse is produced.
- States: IDLE, TOK, DATA_TX, WAIT_HS, WAIT_DATA, HS_TX, FIN.
- IDLE:
  - start=1 latches is_in and clears the retry count.
  - Next state is TOK; busy rises in the cycle after start.
- TOK:
  - tx_req=1, tx_type=1, tx_pid = IN or OUT according to the latched is_in.
  - On tx_done: go to DATA_TX for OUT, or WAIT_DATA for IN.
- DATA_TX (OUT only):
  - tx_req=1, tx_type=2, tx_pid=DATA0.
  - On tx_done: go to WAIT_HS.
- WAIT_HS:
  - rx_en=1, tx_req=0, tx_type=0; the timer increments each cycle.
  - rx_valid with ACK and rx_crc_ok=1 -> FIN with success.
  - rx_valid with STALL -> FIN with fail.
  - NAK, any other PID, CRC error, or timeout -> retry.
- WAIT_DATA:
  - rx_en=1; the timer increments each cycle.
  - rx_valid with DATA0 and rx_crc_ok=1 -> HS_TX.
  - rx_valid with STALL -> FIN with fail.
  - NAK, bad CRC, other PID, or timeout -> retry. No handshake is sent on a bad CRC.
- HS_TX:
  - tx_req=1, tx_type=3, tx_pid=ACK.
  - On tx_done: FIN with success.
- Timer:
  - Clears to 0 on entry to WAIT_HS or WAIT_DATA.
  - Timeout fires on the cycle the timer equals TIMEOUT-1 with no rx_valid.
  - If rx_valid and timeout occur in the same cycle, rx_valid takes priority.
- Retry:
  - If retry count < MAX_RETRY-1: increment it and return to TOK.
  - Otherwise: FIN with fail.
- FIN:
  - done=1 for exactly one cycle, with success or fail set (never both).
  - busy=0 in that same cycle; next state is IDLE.
  - success and fail hold their values until the next start is accepted.
- Bus ownership:
  - rx_en=0 in every state except WAIT_HS and WAIT_DATA.
  - tx_req never asserts while rx_en=1.
- Ignored inputs:
  - rx_valid outside the WAIT states.
  - tx_done outside the transmit states.
  - start while busy or in FIN.
- Widths: timer 8 bits; retry count 4 bits.

Test Plan:
- OUT happy path: start, is_in=0; tx_done after tokens; rx_valid with pid=0010, crc_ok=1 -> tx_pid sequence 0001, 0011; one done with success=1; busy low after.
- IN happy path: start, is_in=1; rx_valid with pid=0011, crc_ok=1 -> tx sequence 1001 then handshake 0010; done with success=1.
- Timeout and exhaustion, TIMEOUT=64, MAX_RETRY=3, device silent -> three IN tokens, each rx_en window exactly 64 cycles; then done with fail=1.
- NAK then ACK: first attempt gets NAK (1010), second gets ACK -> two token/data pairs; success=1.
- STALL in WAIT_DATA -> done with fail=1 immediately, no handshake sent; rx_valid with bad CRC -> retry with no ACK transmitted.
- rx_valid on the timeout cycle wins; start while busy is ignored; rst pulsed during WAIT_HS -> all outputs 0, no done; next start runs normally.
